sha_512_pad: RTL and testbench

Message padder and block former sitting directly upstream of the SHA-512 family compression core. It accepts the message as a stream of big-endian 64-bit words with a byte count on the final word. It emits FIPS 180-4 padded 1024-bit blocks, each with a running block index and the latched operation code (0=512/224, 1=512/256, 2=384, 3=512), ready to drive the core's Data/Index/Operation inputs.

---
 rtl/sha_const.sv | 18 +
 rtl/sha_pad_mask.sv | 28 ++
 rtl/sha_512_pad.sv | 176 +++++++++++++++++
 tb/tb_sha_512_pad.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_const.sv
// Shared constants and state encoding for the SHA-512 family message padder.
package sha_const;

  localparam int unsigned WordW    = 64;
  localparam int unsigned BlockW   = 1024;
  localparam int unsigned LenW     = 128;
  localparam int unsigned NumWords = 16;

  localparam logic [7:0] PadByte = 8'h80;

  typedef enum logic [1:0] {
    StFill,
    StFinal,
    StExtra,
    StEmit
  } pad_state_e;

endpackage

// File: rtl/sha_pad_mask.sv
// Final-word byte mask: keeps the valid leading bytes, drops the 0x80 marker right after them
// and zeroes the rest. Byte counts above 8 saturate to 8.
module sha_pad_mask
  import sha_const::*;
(
  input  logic [WordW-1:0] data_i,
  input  logic [3:0]       bytes_i,
  output logic [WordW-1:0] data_o,
  output logic [3:0]       nbytes_o
);

  logic [3:0] nb;

  assign nb       = (bytes_i > 4'd8) ? 4'd8 : bytes_i;
  assign nbytes_o = nb;

  always_comb begin
    data_o = '0;
    for (int p = 0; p < 8; p++) begin
      if (4'(p) < nb) begin
        data_o[WordW-1-8*p -: 8] = data_i[WordW-1-8*p -: 8];
      end else if (4'(p) == nb) begin
        data_o[WordW-1-8*p -: 8] = PadByte;
      end
    end
  end

endmodule

// File: rtl/sha_512_pad.sv
// FIPS 180-4 message padder: packs 64-bit words into 1024-bit blocks, appends the 0x80 marker
// and the 128-bit bit length, and tags each block with its index and operation.
module sha_512_pad
  import sha_const::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WordW-1:0]  In_Data,
  input  logic [3:0]        In_Bytes,
  input  logic              In_Last,
  input  logic [1:0]        In_Operation,
  input  logic              In_Valid,
  output logic              In_Ready,
  output logic [BlockW-1:0] Out_Data,
  output logic [LenW-1:0]   Out_Index,
  output logic [1:0]        Out_Operation,
  output logic              Out_Last,
  output logic              Out_Valid,
  input  logic              Out_Ready
);

  pad_state_e       state_q, state_d;
  logic [4:0]       wptr_q, wptr_d;
  logic [LenW-1:0]  len_q, len_d;
  logic [LenW-1:0]  index_q, index_d;
  logic [1:0]       op_q, op_d;
  logic             last_q, last_d;
  logic             pend_q, pend_d;      // an extra length-only block must follow
  logic             full_q, full_d;      // last word carried 8 bytes, marker still owed
  logic             pad_ext_q, pad_ext_d; // marker spills into the extra block
  logic [WordW-1:0] blk_q [NumWords];
  logic [WordW-1:0] blk_d [NumWords];

  logic [WordW-1:0] tail_word;
  logic [3:0]       tail_bytes;
  logic [4:0]       used;

  sha_pad_mask u_mask (
    .data_i   (In_Data),
    .bytes_i  (In_Bytes),
    .data_o   (tail_word),
    .nbytes_o (tail_bytes)
  );

  assign used          = wptr_q + {4'b0, full_q};
  assign In_Ready      = (state_q == StFill);
  assign Out_Valid     = (state_q == StEmit);
  assign Out_Index     = index_q;
  assign Out_Operation = op_q;
  assign Out_Last      = last_q;

  always_comb begin
    Out_Data = '0;
    for (int i = 0; i < NumWords; i++) begin
      Out_Data[BlockW-1-WordW*i -: WordW] = blk_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    len_d     = len_q;
    index_d   = index_q;
    op_d      = op_q;
    last_d    = last_q;
    pend_d    = pend_q;
    full_d    = full_q;
    pad_ext_d = pad_ext_q;
    for (int i = 0; i < NumWords; i++) begin
      blk_d[i] = blk_q[i];
    end

    unique case (state_q)
      StFill: begin
        if (In_Valid) begin
          blk_d[wptr_q[3:0]] = In_Last ? tail_word : In_Data;
          wptr_d = wptr_q + 5'd1;
          if (wptr_q == 5'd0 && index_q == '0) begin
            op_d = In_Operation;
          end
          if (In_Last) begin
            len_d   = len_q + {{(LenW-7){1'b0}}, tail_bytes, 3'b000};
            full_d  = (tail_bytes == 4'd8);
            state_d = StFinal;
          end else begin
            len_d = len_q + LenW'(64);
            if (wptr_q == 5'd15) begin
              last_d  = 1'b0;
              state_d = StEmit;
            end
          end
        end
      end

      StFinal: begin
        if (full_q && wptr_q < 5'd16) begin
          blk_d[wptr_q[3:0]] = {PadByte, 56'h0};
        end
        for (int i = 0; i < NumWords; i++) begin
          if (5'(i) >= used) blk_d[i] = '0;
        end
        pad_ext_d = full_q && (wptr_q == 5'd16);
        if (used <= 5'd14) begin
          blk_d[14] = len_q[LenW-1:WordW];
          blk_d[15] = len_q[WordW-1:0];
          last_d    = 1'b1;
        end else begin
          last_d = 1'b0;
          pend_d = 1'b1;
        end
        state_d = StEmit;
      end

      StExtra: begin
        for (int i = 0; i < NumWords; i++) begin
          blk_d[i] = '0;
        end
        if (pad_ext_q) blk_d[0] = {PadByte, 56'h0};
        blk_d[14] = len_q[LenW-1:WordW];
        blk_d[15] = len_q[WordW-1:0];
        last_d    = 1'b1;
        pend_d    = 1'b0;
        state_d   = StEmit;
      end

      StEmit: begin
        if (Out_Ready) begin
          index_d = index_q + LenW'(1);
          if (pend_q) begin
            state_d = StExtra;
          end else begin
            if (last_q) begin
              index_d = '0;
              len_d   = '0;
            end
            wptr_d  = '0;
            state_d = StFill;
          end
        end
      end

      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StFill;
      wptr_q    <= '0;
      len_q     <= '0;
      index_q   <= '0;
      op_q      <= '0;
      last_q    <= 1'b0;
      pend_q    <= 1'b0;
      full_q    <= 1'b0;
      pad_ext_q <= 1'b0;
      for (int i = 0; i < NumWords; i++) begin
        blk_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      len_q     <= len_d;
      index_q   <= index_d;
      op_q      <= op_d;
      last_q    <= last_d;
      pend_q    <= pend_d;
      full_q    <= full_d;
      pad_ext_q <= pad_ext_d;
      for (int i = 0; i < NumWords; i++) begin
        blk_q[i] <= blk_d[i];
      end
    end
  end

endmodule

// File: tb/tb_sha_512_pad.sv
// Bench for sha_512_pad: byte-level FIPS 180-4 padding model versus the streamed block output.
module tb_sha_512_pad;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   In_Data;
  logic [3:0]    In_Bytes;
  logic          In_Last;
  logic [1:0]    In_Operation;
  logic          In_Valid;
  logic          In_Ready;
  logic [1023:0] Out_Data;
  logic [127:0]  Out_Index;
  logic [1:0]    Out_Operation;
  logic          Out_Last;
  logic          Out_Valid;
  logic          Out_Ready;

  always #5 clk = ~clk;

  sha_512_pad dut (
    .clk           (clk),
    .rst           (rst),
    .In_Data       (In_Data),
    .In_Bytes      (In_Bytes),
    .In_Last       (In_Last),
    .In_Operation  (In_Operation),
    .In_Valid      (In_Valid),
    .In_Ready      (In_Ready),
    .Out_Data      (Out_Data),
    .Out_Index     (Out_Index),
    .Out_Operation (Out_Operation),
    .Out_Last      (Out_Last),
    .Out_Valid     (Out_Valid),
    .Out_Ready     (Out_Ready)
  );

  int n_vec = 0;
  int n_err = 0;

  byte unsigned  msg_q[$];
  logic [1:0]    cur_op;
  int            tail_mode;   // 0: random tail encoding, 1: last word exactly 8 bytes
  logic [1023:0] exp_data[$];
  logic [127:0]  exp_idx[$];
  logic          exp_last[$];
  logic [1:0]    exp_op[$];
  logic [63:0]   w_data[$];
  logic [3:0]    w_bytes[$];
  logic [1023:0] got_blk[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wd(input logic [1023:0] b, input int i);
    return b[1023-64*i -: 64];
  endfunction

  // Padded message as bytes: msg, 0x80, zeros to 112 mod 128, 16-byte big-endian bit length.
  task automatic model();
    byte unsigned  p[$];
    logic [127:0]  bits;
    logic [1023:0] blk;
    int            nb;
    p    = msg_q;
    bits = 128'(msg_q.size()) * 128'd8;
    p.push_back(8'h80);
    while (p.size() % 128 != 112) p.push_back(8'h00);
    for (int k = 15; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    nb = p.size() / 128;
    for (int b = 0; b < nb; b++) begin
      blk = '0;
      for (int j = 0; j < 128; j++) blk[1023-8*j -: 8] = p[b*128+j];
      exp_data.push_back(blk);
      exp_idx.push_back(128'(b));
      exp_last.push_back(b == nb - 1);
      exp_op.push_back(cur_op);
    end
  endtask

  // Splits msg_q into words; bytes past the message end are random to exercise the mask.
  task automatic build_words();
    int          n;
    int          nw;
    int          cnt;
    logic [63:0] d;
    w_data.delete();
    w_bytes.delete();
    n  = msg_q.size();
    nw = (n + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      d   = {$urandom, $urandom};
      cnt = (n - 8 * w > 8) ? 8 : n - 8 * w;
      for (int k = 0; k < cnt; k++) d[63-8*k -: 8] = msg_q[8*w+k];
      w_data.push_back(d);
      w_bytes.push_back((w == nw - 1) ? 4'(cnt) : 4'($urandom_range(0, 15)));
    end
    if (n % 8 == 0) begin
      if (n == 0 || (tail_mode == 0 && $urandom_range(0, 1) == 0)) begin
        w_data.push_back({$urandom, $urandom});
        w_bytes.push_back(4'd0);
      end else if (tail_mode == 0) begin
        w_bytes[nw-1] = 4'($urandom_range(8, 15));
      end
    end
  endtask

  task automatic cmp_block(input string tag);
    logic [1023:0] e;
    e = exp_data[0];
    for (int i = 0; i < 16; i++) chk($sformatf("%s w%0d", tag, i), wd(Out_Data, i), wd(e, i));
    chk({tag, " index"}, Out_Index, exp_idx[0]);
    chk({tag, " last"}, Out_Last, exp_last[0]);
    chk({tag, " op"}, Out_Operation, exp_op[0]);
    got_blk.push_back(Out_Data);
    void'(exp_data.pop_front());
    void'(exp_idx.pop_front());
    void'(exp_last.pop_front());
    void'(exp_op.pop_front());
  endtask

  task automatic run_msg(input string tag, input int vpct, input int rpct);
    int w   = 0;
    int cyc = 0;
    bit hs;
    model();
    build_words();
    got_blk.delete();
    while ((w < w_data.size() || exp_data.size() != 0) && cyc < 4000) begin
      In_Valid = (w < w_data.size()) && ($urandom_range(1, 100) <= vpct);
      if (In_Valid) begin
        In_Data      = w_data[w];
        In_Bytes     = w_bytes[w];
        In_Last      = (w == w_data.size() - 1);
        In_Operation = (w == 0) ? cur_op : 2'($urandom_range(0, 3));
      end else begin
        In_Data      = {$urandom, $urandom};
        In_Bytes     = 4'($urandom_range(0, 15));
        In_Last      = 1'b0;
        In_Operation = 2'($urandom_range(0, 3));
      end
      Out_Ready = ($urandom_range(1, 100) <= rpct);
      if (Out_Valid) chk({tag, " in_ready during emit"}, In_Ready, 1'b0);
      if (Out_Valid && Out_Ready) begin
        if (exp_data.size() == 0) chk({tag, " spurious block"}, Out_Valid, 1'b0);
        else cmp_block(tag);
      end
      hs = In_Valid && In_Ready;
      @(posedge clk);
      #1;
      if (hs) w++;
      cyc++;
    end
    chk({tag, " completed in budget"}, cyc < 4000, 1'b1);
    exp_data.delete();
    exp_idx.delete();
    exp_last.delete();
    exp_op.delete();
    In_Valid  = 1'b0;
    In_Last   = 1'b0;
    Out_Ready = 1'b0;
  endtask

  task automatic set_abc();
    msg_q.delete();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
    cur_op = 2'd3;
  endtask

  task automatic set_random_msg(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
  endtask

  logic [1023:0] snap;
  logic [127:0]  snap_idx;

  initial begin
    rst          = 1'b0;
    In_Data      = '0;
    In_Bytes     = '0;
    In_Last      = 1'b0;
    In_Operation = '0;
    In_Valid     = 1'b0;
    Out_Ready    = 1'b0;
    tail_mode    = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    chk("reset in_ready", In_Ready, 1'b1);
    chk("reset out_valid", Out_Valid, 1'b0);
    chk("reset out_index", Out_Index, '0);
    chk("reset out_last", Out_Last, 1'b0);
    chk("reset out_op", Out_Operation, 2'd0);
    chk("reset out_data", 128'(Out_Data != '0), '0);

    // "abc" with strict timing and 5 cycles of backpressure.
    set_abc();
    model();
    got_blk.delete();
    In_Valid     = 1'b1;
    In_Data      = 64'h6162_6300_0000_0000;
    In_Bytes     = 4'd3;
    In_Last      = 1'b1;
    In_Operation = 2'd3;
    chk("abc in_ready", In_Ready, 1'b1);
    @(posedge clk);
    #1;
    In_Valid = 1'b0;
    In_Last  = 1'b0;
    chk("abc final cycle no valid", Out_Valid, 1'b0);
    chk("abc final cycle in_ready", In_Ready, 1'b0);
    @(posedge clk);
    #1;
    chk("abc valid two cycles after accept", Out_Valid, 1'b1);
    snap     = Out_Data;
    snap_idx = Out_Index;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp hold valid", Out_Valid, 1'b1);
      chk("bp hold data", 128'(Out_Data === snap), 1'b1);
      chk("bp hold index", Out_Index, snap_idx);
      chk("bp in_ready low", In_Ready, 1'b0);
    end
    if (Out_Valid) cmp_block("abc");
    Out_Ready = 1'b1;
    @(posedge clk);
    #1;
    Out_Ready = 1'b0;
    chk("abc valid drops after handshake", Out_Valid, 1'b0);
    chk("abc fill re-entered", In_Ready, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("abc single block", Out_Valid, 1'b0);
    end
    chk("abc blocks", got_blk.size(), 1);
    chk("abc word0", wd(got_blk[0], 0), 64'h6162_6380_0000_0000);
    chk("abc word15", wd(got_blk[0], 15), 64'h18);

    // Empty message.
    msg_q.delete();
    cur_op = 2'd1;
    run_msg("empty", 100, 100);
    chk("empty blocks", got_blk.size(), 1);
    if (got_blk.size() == 1) chk("empty word0", wd(got_blk[0], 0), 64'h8000_0000_0000_0000);

    // 112 bytes: marker fills slot 14, length needs an extra block.
    tail_mode = 1;
    set_random_msg(112);
    cur_op = 2'd2;
    run_msg("m112", 100, 100);
    chk("m112 blocks", got_blk.size(), 2);
    if (got_blk.size() == 2) begin
      chk("m112 b0 w14", wd(got_blk[0], 14), 64'h8000_0000_0000_0000);
      chk("m112 b1 w15", wd(got_blk[1], 15), 64'h380);
    end

    // 128 bytes: marker spills into slot 0 of the extra block.
    set_random_msg(128);
    cur_op = 2'd0;
    run_msg("m128", 100, 100);
    chk("m128 blocks", got_blk.size(), 2);
    if (got_blk.size() == 2) begin
      chk("m128 b1 w0", wd(got_blk[1], 0), 64'h8000_0000_0000_0000);
      chk("m128 b1 w15", wd(got_blk[1], 15), 64'h400);
    end
    tail_mode = 0;

    // Reset after 7 accepted words of a longer message, then "abc".
    In_Valid = 1'b1;
    In_Last  = 1'b0;
    for (int k = 0; k < 7; k++) begin
      In_Data      = {$urandom, $urandom};
      In_Operation = 2'd1;
      @(posedge clk);
      #1;
    end
    In_Valid = 1'b0;
    rst      = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("mid reset in_ready", In_Ready, 1'b1);
    chk("mid reset out_valid", Out_Valid, 1'b0);
    set_abc();
    run_msg("abc after reset", 100, 100);
    chk("abc after reset blocks", got_blk.size(), 1);
    if (got_blk.size() == 1) chk("abc after reset word15", wd(got_blk[0], 15), 64'h18);

    // Random messages, random valid gaps and backpressure.
    for (int m = 0; m < 25; m++) begin
      set_random_msg($urandom_range(0, 300));
      cur_op = 2'($urandom_range(0, 3));
      run_msg($sformatf("rnd%0d", m), $urandom_range(30, 100), $urandom_range(30, 100));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
